// File: rtl/mul32_wt8_seq_pkg.sv
// rtl/mul32_wt8_seq_pkg.sv - shared widths, state encoding and helpers for the sequential multiplier
// Contents: OPW (operand width), STEPS (byte-product steps), STEP_W, state_t, mag().
package mul32_wt8_seq_pkg;

    localparam int OPW    = 32;
    localparam int STEPS  = 16;
    localparam int STEP_W = $clog2(STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Magnitude of a signed operand; 0x80000000 maps to itself and is then
    // treated as an unsigned 32-bit value.
    function automatic logic [OPW-1:0] mag(input logic [OPW-1:0] v, input logic is_signed);
        return (is_signed && v[OPW-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/mul32_wt8_seq_if.sv
// rtl/mul32_wt8_seq_if.sv - request/response bundle of the sequential multiplier
// Signals: start, signed_op, a, b, flush (requester -> multiplier);
//          busy, done, result (multiplier -> requester).
interface mul32_wt8_seq_if;
    import mul32_wt8_seq_pkg::*;

    logic                 start;
    logic                 signed_op;
    logic [OPW-1:0]       a;
    logic [OPW-1:0]       b;
    logic                 flush;
    logic                 busy;
    logic                 done;
    logic [2*OPW-1:0]     result;

    modport master (
        output start, signed_op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, signed_op, a, b, flush,
        output busy, done, result
    );

endinterface

// File: rtl/mul32_wt8_seq_wallace_tree8.sv
// rtl/mul32_wt8_seq_wallace_tree8.sv - 8x8 unsigned Wallace-tree multiplier (combinational)
// Ports: a_i[7:0], b_i[7:0] operands; p_o[15:0] product.
module wallace_tree8 (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);

    function automatic logic [15:0] csa_sum(input logic [15:0] x, input logic [15:0] y,
                                            input logic [15:0] z);
        return x ^ y ^ z;
    endfunction

    function automatic logic [15:0] csa_carry(input logic [15:0] x, input logic [15:0] y,
                                              input logic [15:0] z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    logic [15:0] pp [8];

    for (genvar k = 0; k < 8; k++) begin : g_pp
        assign pp[k] = b_i[k] ? ({8'b0, a_i} << k) : 16'b0;
    end

    // Reduction 8 -> 6 -> 4 -> 3 -> 2 rows; the product fits in 16 bits so
    // carries shifted out of the top are always zero.
    logic [15:0] s1_s0, s1_c0, s1_s1, s1_c1;
    logic [15:0] s2_s0, s2_c0, s2_s1, s2_c1;
    logic [15:0] s3_s,  s3_c;
    logic [15:0] s4_s,  s4_c;

    assign s1_s0 = csa_sum  (pp[0], pp[1], pp[2]);
    assign s1_c0 = csa_carry(pp[0], pp[1], pp[2]);
    assign s1_s1 = csa_sum  (pp[3], pp[4], pp[5]);
    assign s1_c1 = csa_carry(pp[3], pp[4], pp[5]);

    assign s2_s0 = csa_sum  (s1_s0, s1_c0, s1_s1);
    assign s2_c0 = csa_carry(s1_s0, s1_c0, s1_s1);
    assign s2_s1 = csa_sum  (s1_c1, pp[6], pp[7]);
    assign s2_c1 = csa_carry(s1_c1, pp[6], pp[7]);

    assign s3_s  = csa_sum  (s2_s0, s2_c0, s2_s1);
    assign s3_c  = csa_carry(s2_s0, s2_c0, s2_s1);

    assign s4_s  = csa_sum  (s3_s, s3_c, s2_c1);
    assign s4_c  = csa_carry(s3_s, s3_c, s2_c1);

    assign p_o   = s4_s + s4_c;

endmodule

// File: rtl/mul32_wt8_seq.sv
// rtl/mul32_wt8_seq.sv - 32x32 signed/unsigned multiplier built from one 8x8 multiplier over 16 steps
// Ports: clk, rst (async, active-high);
//        bus (slave): start/signed_op/a/b/flush in, busy/done/result out.
module mul32_wt8_seq
    import mul32_wt8_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    mul32_wt8_seq_if.slave  bus
);

    state_t              state_q;
    logic [OPW-1:0]      ma_q;
    logic [OPW-1:0]      mb_q;
    logic                sign_q;
    logic [STEP_W-1:0]   step_q;
    logic [2*OPW-1:0]    acc_q;
    logic [2*OPW-1:0]    acc_d;
    logic [2*OPW-1:0]    result_q;
    logic                busy_q;
    logic                done_q;

    // Step k multiplies byte k[3:2] of ma by byte k[1:0] of mb.
    logic [1:0]          i_sel;
    logic [1:0]          j_sel;
    logic [2:0]          byte_pos;
    logic [7:0]          byte_a;
    logic [7:0]          byte_b;
    logic [15:0]         pp;

    assign i_sel    = step_q[3:2];
    assign j_sel    = step_q[1:0];
    assign byte_pos = {1'b0, i_sel} + {1'b0, j_sel};
    assign byte_a   = ma_q[{i_sel, 3'b000} +: 8];
    assign byte_b   = mb_q[{j_sel, 3'b000} +: 8];

    wallace_tree8 u_wt (
        .a_i (byte_a),
        .b_i (byte_b),
        .p_o (pp)
    );

    assign acc_d = acc_q + ({{(2*OPW-16){1'b0}}, pp} << {byte_pos, 3'b000});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ma_q     <= '0;
            mb_q     <= '0;
            sign_q   <= 1'b0;
            step_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        ma_q    <= mag(bus.a, bus.signed_op);
                        mb_q    <= mag(bus.b, bus.signed_op);
                        sign_q  <= bus.signed_op & (bus.a[OPW-1] ^ bus.b[OPW-1]);
                        acc_q   <= '0;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        acc_q  <= acc_d;
                        step_q <= step_q + 1'b1;
                        if (step_q == STEP_W'(STEPS - 1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (!bus.flush) begin
                        result_q <= sign_q ? -acc_q : acc_q;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mul32_wt8_seq.sv
// tb/tb_mul32_wt8_seq.sv - self-checking bench for mul32_wt8_seq
module tb_mul32_wt8_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mul32_wt8_seq_if bus ();

    mul32_wt8_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q [$];
    logic [63:0] last_result = 64'd0;

    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive a request for the next rising edge; caller is at a falling edge.
    task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b, input bit push);
        bus.start     = 1'b1;
        bus.signed_op = s;
        bus.a         = a;
        bus.b         = b;
        if (push) exp_q.push_back(model(s, a, b));
    endtask

    // Waits for done after a launch; optionally raises start again at the
    // falling edge following edge E<inject_at> to show it is ignored.
    task automatic wait_result(input string tag, input int inject_at);
        int          n;
        logic [63:0] expv;
        n = 0;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
            bus.start = (n == inject_at);
            if (n == inject_at) begin
                bus.a = 32'h0000_FFFF;
                bus.b = 32'h0000_0003;
            end
        end
        bus.start = 1'b0;
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        check({tag, "_lat"}, 64'(n), 64'd17);
        check({tag, "_nbusy"}, 64'(bus.busy), 64'd0);
        if (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            check({tag, "_res"}, bus.result, expv);
        end
        last_result = bus.result;
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.flush     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",   64'(bus.busy), 64'd0);
        check("rst_done",   64'(bus.done), 64'd0);
        check("rst_result", bus.result,    64'd0);
        rst = 1'b0;
        @(negedge clk);

        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_result("u_ff", -1);
        check("u_ff_const", bus.result, 64'hFFFF_FFFE_0000_0001);

        // Back-to-back: launched in the done cycle.
        launch(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_result("s_ff", -1);
        check("s_ff_const", bus.result, 64'h0000_0000_0000_0001);

        launch(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        wait_result("s_min", -1);
        check("s_min_const", bus.result, 64'hC000_0000_8000_0000);

        launch(1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 1'b1);
        wait_result("s_zero", -1);
        check("s_zero_const", bus.result, 64'h0);

        // Flush while CALC is at step 5.
        @(negedge clk);
        launch(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("fl_busy",   64'(bus.busy), 64'd0);
        check("fl_done",   64'(bus.done), 64'd0);
        check("fl_result", bus.result,    last_result);
        launch(1'b0, 32'd3, 32'd7, 1'b1);
        wait_result("u_3x7", -1);
        check("u_3x7_const", bus.result, 64'd21);

        // flush together with start in IDLE: not accepted.
        @(negedge clk);
        launch(1'b0, 32'd5, 32'd5, 1'b0);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("fs_busy", 64'(bus.busy), 64'd0);
        repeat (3) @(negedge clk);
        check("fs_idle", 64'(bus.busy), 64'd0);

        // A start at step 8 is ignored.
        launch(1'b0, 32'd1000, 32'd2000, 1'b1);
        wait_result("ign", 8);
        @(negedge clk);
        check("ign_nodone", 64'(bus.done), 64'd0);
        check("ign_nbusy",  64'(bus.busy), 64'd0);
        check("ign_hold",   bus.result,    64'd2000000);

        for (int k = 0; k < 6; k++) begin
            launch(1'(k & 1), $urandom, $urandom, 1'b1);
            wait_result($sformatf("rnd%0d", k), -1);
        end

        // Asynchronous reset mid-operation, then immediate restart.
        @(negedge clk);
        launch(1'b1, 32'hDEAD_BEEF, 32'h0000_0011, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("ar_busy",   64'(bus.busy), 64'd0);
        check("ar_done",   64'(bus.done), 64'd0);
        check("ar_result", bus.result,    64'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        launch(1'b1, 32'hFFFF_FFF9, 32'h0000_0006, 1'b1);
        wait_result("after_rst", -1);
        check("after_rst_const", bus.result, 64'hFFFF_FFFF_FFFF_FFD6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
